// File: rtl/airlock_seq_ctrl.sv
// Airlock sequencer: tracks chamber water level through fill/settle/drain phases
// and interlocks the inner and outer doors against the chamber state.
module airlock_seq_ctrl #(
  parameter int unsigned LEVEL_MAX   = 16,
  parameter int unsigned FILL_RATE   = 4,
  parameter int unsigned DRAIN_RATE  = 2,
  parameter int unsigned LVL_W       = 8,
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned WAIT_W      = 8
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic             fill_req,
  input  logic             drain_req,
  input  logic             abort,
  input  logic             innerdoor_sw,
  input  logic             outerdoor_sw,
  output logic             filling,
  output logic             draining,
  output logic             waiting,
  output logic             innerdoor_open,
  output logic             outerdoor_open,
  output logic             fill_done,
  output logic             drain_done,
  output logic             wait_done,
  output logic             reject,
  output logic [LVL_W-1:0] level,
  output logic [2:0]       state_code
);

  typedef enum logic [2:0] {
    S_DRY        = 3'd0,
    S_FILL       = 3'd1,
    S_SETTLE_WET = 3'd2,
    S_WET        = 3'd3,
    S_DRAIN      = 3'd4,
    S_SETTLE_DRY = 3'd5
  } state_t;

  localparam logic [LVL_W:0]    C_MAX_EXT   = (LVL_W+1)'(LEVEL_MAX);
  localparam logic [LVL_W:0]    C_FILL_EXT  = (LVL_W+1)'(FILL_RATE);
  localparam logic [LVL_W:0]    C_DRAIN_EXT = (LVL_W+1)'(DRAIN_RATE);
  localparam logic [LVL_W-1:0]  C_MAX       = LVL_W'(LEVEL_MAX);
  localparam logic [LVL_W-1:0]  C_DRAIN     = LVL_W'(DRAIN_RATE);
  localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);

  state_t            r_state,      w_state_nxt;
  logic [LVL_W-1:0]  r_level,      w_level_nxt;
  logic [WAIT_W-1:0] r_cnt,        w_cnt_nxt;
  logic              r_inner,      w_inner_nxt;
  logic              r_outer,      w_outer_nxt;
  logic              r_fill_done,  w_fill_done_nxt;
  logic              r_drain_done, w_drain_done_nxt;
  logic              r_wait_done,  w_wait_done_nxt;
  logic              r_reject,     w_reject_nxt;
  logic [LVL_W:0]    w_fill_sum;

  // One extra bit so the saturating add never wraps
  assign w_fill_sum = {1'b0, r_level} + C_FILL_EXT;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state      <= S_DRY;
      r_level      <= '0;
      r_cnt        <= '0;
      r_inner      <= 1'b0;
      r_outer      <= 1'b0;
      r_fill_done  <= 1'b0;
      r_drain_done <= 1'b0;
      r_wait_done  <= 1'b0;
      r_reject     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_level      <= w_level_nxt;
      r_cnt        <= w_cnt_nxt;
      r_inner      <= w_inner_nxt;
      r_outer      <= w_outer_nxt;
      r_fill_done  <= w_fill_done_nxt;
      r_drain_done <= w_drain_done_nxt;
      r_wait_done  <= w_wait_done_nxt;
      r_reject     <= w_reject_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_level_nxt      = r_level;
    w_cnt_nxt        = r_cnt;
    w_fill_done_nxt  = 1'b0;
    w_drain_done_nxt = 1'b0;
    w_wait_done_nxt  = 1'b0;
    w_reject_nxt     = 1'b0;
    w_inner_nxt      = (r_state == S_DRY) && innerdoor_sw;
    w_outer_nxt      = (r_state == S_WET) && outerdoor_sw;

    case (r_state)
      S_DRY: begin
        if (fill_req) begin
          if (!innerdoor_sw && !r_inner) w_state_nxt  = S_FILL;
          else                           w_reject_nxt = 1'b1;
        end
      end
      S_FILL: begin
        if (abort) begin
          w_state_nxt = S_DRAIN;
        end else if (w_fill_sum >= C_MAX_EXT) begin
          w_level_nxt     = C_MAX;
          w_state_nxt     = S_SETTLE_WET;
          w_cnt_nxt       = '0;
          w_fill_done_nxt = 1'b1;
        end else begin
          w_level_nxt = LVL_W'(w_fill_sum);
        end
      end
      S_SETTLE_WET: begin
        if (r_cnt >= C_WAIT_LAST) begin
          w_state_nxt     = S_WET;
          w_wait_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + WAIT_W'(1);
        end
      end
      S_WET: begin
        if (drain_req) begin
          if (!outerdoor_sw && !r_outer) w_state_nxt  = S_DRAIN;
          else                           w_reject_nxt = 1'b1;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          w_state_nxt = S_FILL;
        end else if ({1'b0, r_level} <= C_DRAIN_EXT) begin
          w_level_nxt      = '0;
          w_state_nxt      = S_SETTLE_DRY;
          w_cnt_nxt        = '0;
          w_drain_done_nxt = 1'b1;
        end else begin
          w_level_nxt = r_level - C_DRAIN;
        end
      end
      S_SETTLE_DRY: begin
        if (r_cnt >= C_WAIT_LAST) begin
          w_state_nxt     = S_DRY;
          w_wait_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + WAIT_W'(1);
        end
      end
      default: w_state_nxt = S_DRY;
    endcase
  end

  assign filling        = (r_state == S_FILL);
  assign draining       = (r_state == S_DRAIN);
  assign waiting        = (r_state == S_SETTLE_WET) || (r_state == S_SETTLE_DRY);
  assign state_code     = r_state;
  assign level          = r_level;
  assign innerdoor_open = r_inner;
  assign outerdoor_open = r_outer;
  assign fill_done      = r_fill_done;
  assign drain_done     = r_drain_done;
  assign wait_done      = r_wait_done;
  assign reject         = r_reject;

endmodule
